// File: rtl/pcie_axi_master_req_filter.sv
// Request-TLP admission filter ahead of the PCIe AXI master: forwards supported
// MRd/MWr through a registered skid stage and discards everything else whole.
module pcie_axi_master_req_filter #(
  parameter int TLP_DATA_WIDTH   = 256,
  parameter int TLP_HDR_WIDTH    = 128,
  parameter int TLP_SEG_COUNT    = 1,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TLP_DATA_WIDTH-1:0]   in_tlp_data,
  input  logic [TLP_HDR_WIDTH-1:0]    in_tlp_hdr,
  input  logic                        in_tlp_valid,
  input  logic                        in_tlp_sop,
  input  logic                        in_tlp_eop,
  output logic                        in_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0]   out_tlp_data,
  output logic [TLP_HDR_WIDTH-1:0]    out_tlp_hdr,
  output logic                        out_tlp_valid,
  output logic                        out_tlp_sop,
  output logic                        out_tlp_eop,
  input  logic                        out_tlp_ready,
  input  logic                        enable,
  input  logic [2:0]                  max_payload_size,
  output logic                        status_error_uncor,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  generate
    if (TLP_SEG_COUNT != 1 || TLP_HDR_WIDTH != 128) begin : g_bad_cfg
      $error("pcie_axi_master_req_filter: needs TLP_SEG_COUNT=1 and TLP_HDR_WIDTH=128");
    end
  endgenerate

  typedef struct packed {
    logic [TLP_HDR_WIDTH-1:0]  hdr;
    logic [TLP_DATA_WIDTH-1:0] data;
    logic                      sop;
    logic                      eop;
  } beat_t;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                state_q, state_d;
  logic                  run_q;
  beat_t                 in_beat, out_q, skid_q;
  logic                  out_vld_q, skid_vld_q;
  logic                  err_q;
  logic [DROP_COUNT_WIDTH-1:0] cnt_q;
  logic                  hs, fwd, drop_evt;

  assign in_beat = '{hdr: in_tlp_hdr, data: in_tlp_data, sop: in_tlp_sop, eop: in_tlp_eop};

  // Header decode: only fmt 000..011 with type 00000 are memory requests
  logic [7:0]  fmt_type;
  logic        is_mem, is_wr, oversize, admit;
  logic [10:0] len_dw, limit_dw;
  logic        unused_hdr_bits;

  assign fmt_type = in_tlp_hdr[127:120];
  assign is_mem   = !fmt_type[7] && (fmt_type[4:0] == 5'd0);
  assign is_wr    = fmt_type[6];
  assign len_dw   = (in_tlp_hdr[105:96] == 10'd0) ? 11'd1024 : {1'b0, in_tlp_hdr[105:96]};
  // Reserved MPS codes 6/7 shift the limit out of 11 bits, so every write drops
  assign limit_dw = 11'd32 << max_payload_size;
  assign oversize = is_wr && (len_dw > limit_dw);
  assign admit    = is_mem && !oversize;
  assign unused_hdr_bits = ^{in_tlp_hdr[119:106], in_tlp_hdr[95:0]};

  // Ready only looks at registered skid state, never at out_tlp_ready
  always_comb begin
    in_tlp_ready = 1'b0;
    case (state_q)
      IDLE:    in_tlp_ready = run_q && !skid_vld_q && (enable || !in_tlp_sop);
      PASS:    in_tlp_ready = run_q && !skid_vld_q;
      DROP:    in_tlp_ready = run_q;
      default: in_tlp_ready = 1'b0;
    endcase
  end

  assign hs = in_tlp_valid && in_tlp_ready;

  always_comb begin
    state_d  = state_q;
    fwd      = 1'b0;
    drop_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (!in_tlp_sop) begin
            drop_evt = 1'b1;
          end else if (admit) begin
            fwd = 1'b1;
            if (!in_tlp_eop) state_d = PASS;
          end else begin
            drop_evt = 1'b1;
            if (!in_tlp_eop) state_d = DROP;
          end
        end
      end
      PASS: begin
        if (hs) begin
          fwd = 1'b1;
          if (in_tlp_eop) state_d = IDLE;
        end
      end
      DROP: begin
        if (hs && in_tlp_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      err_q   <= drop_evt;
      if (drop_evt && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output register backed by a one-entry skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else if (!out_vld_q || out_tlp_ready) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else if (fwd) begin
        out_q     <= in_beat;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (fwd) begin
      skid_q     <= in_beat;
      skid_vld_q <= 1'b1;
    end
  end

  assign out_tlp_data       = out_q.data;
  assign out_tlp_hdr        = out_q.hdr;
  assign out_tlp_sop        = out_q.sop;
  assign out_tlp_eop        = out_q.eop;
  assign out_tlp_valid      = out_vld_q;
  assign status_error_uncor = err_q;
  assign drop_count         = cnt_q;

endmodule
